// File: rtl/vproc_pkg.sv
// Shared vector-processor types used by the cfg unit and the decoder.
// cfg_op values are laid out as {target[2:0], kind[1:0]}. For CSR targets,
// kind selects write (0), set (1) or clear (2).
package vproc_pkg;

  typedef enum logic [1:0] {
    VSEW_8       = 2'd0,
    VSEW_16      = 2'd1,
    VSEW_32      = 2'd2,
    VSEW_INVALID = 2'd3
  } cfg_vsew;

  // RVV vlmul encoding, so vtype reads need no translation
  typedef enum logic [2:0] {
    LMUL_1       = 3'b000,
    LMUL_2       = 3'b001,
    LMUL_4       = 3'b010,
    LMUL_8       = 3'b011,
    LMUL_INVALID = 3'b100,
    LMUL_F8      = 3'b101,
    LMUL_F4      = 3'b110,
    LMUL_F2      = 3'b111
  } cfg_lmul;

  typedef enum logic [1:0] {
    VXRM_RNU = 2'd0,
    VXRM_RNE = 2'd1,
    VXRM_RDN = 2'd2,
    VXRM_ROD = 2'd3
  } cfg_vxrm;

  typedef enum logic [4:0] {
    CFG_VSETVL       = 5'b000_00,
    CFG_VTYPE_READ   = 5'b000_01,
    CFG_VL_READ      = 5'b000_10,
    CFG_VLENB_READ   = 5'b000_11,
    CFG_VSTART_WRITE = 5'b001_00,
    CFG_VSTART_SET   = 5'b001_01,
    CFG_VSTART_CLEAR = 5'b001_10,
    CFG_VXSAT_WRITE  = 5'b010_00,
    CFG_VXSAT_SET    = 5'b010_01,
    CFG_VXSAT_CLEAR  = 5'b010_10,
    CFG_VXRM_WRITE   = 5'b011_00,
    CFG_VXRM_SET     = 5'b011_01,
    CFG_VXRM_CLEAR   = 5'b011_10,
    CFG_VCSR_WRITE   = 5'b100_00,
    CFG_VCSR_SET     = 5'b100_01,
    CFG_VCSR_CLEAR   = 5'b100_10
  } cfg_op;

  typedef struct packed {
    cfg_op      op;
    cfg_vsew    vsew;
    cfg_lmul    lmul;
    logic [1:0] agnostic;  // {vma, vta}
    logic       keep_vl;
    logic       vlmax;
  } op_mode_cfg;

  typedef enum logic [1:0] {
    CFG_IDLE,
    CFG_WAIT_COMMIT,
    CFG_RESULT
  } cfg_unit_state;

  // Fields sized for the widest supported VREG_W; narrower units keep the
  // upper bits at zero.
  localparam int unsigned CFG_VL_MAXW     = 16;
  localparam int unsigned CFG_VSTART_MAXW = 15;

  typedef struct packed {
    logic                       vill;
    cfg_vsew                    vsew;
    cfg_lmul                    lmul;
    logic [1:0]                 agnostic;
    logic [CFG_VL_MAXW-1:0]     vl;
    logic [CFG_VSTART_MAXW-1:0] vstart;
    cfg_vxrm                    vxrm;
    logic                       vxsat;
  } cfg_state;

  localparam cfg_state CFG_STATE_RESET = '{
    vill:     1'b1,
    vsew:     VSEW_8,
    lmul:     LMUL_1,
    agnostic: 2'b00,
    vl:       '0,
    vstart:   '0,
    vxrm:     VXRM_RNU,
    vxsat:    1'b0
  };

endpackage

// File: rtl/vproc_cfg_vlmax.sv
// VLMAX = VREG_W * LMUL / SEW. Fractional LMUL is applied as a right shift.
// vill is flagged for reserved vsew/lmul encodings or when VLMAX is zero.
module vproc_cfg_vlmax import vproc_pkg::*; #(
  parameter int unsigned VREG_W = 128
) (
  input  logic [1:0]              vsew,
  input  logic [2:0]              lmul,
  output logic [$clog2(VREG_W):0] vlmax,
  output logic                    vill
);

  localparam int unsigned VL_W = $clog2(VREG_W) + 1;

  logic [31:0] base;
  logic [31:0] elems;

  // elements per register at this SEW, then scaled by LMUL
  always_comb begin
    base  = 32'(VREG_W / 8) >> vsew;
    elems = '0;
    case (cfg_lmul'(lmul))
      LMUL_1:  elems = base;
      LMUL_2:  elems = base << 1;
      LMUL_4:  elems = base << 2;
      LMUL_8:  elems = base << 3;
      LMUL_F2: elems = base >> 1;
      LMUL_F4: elems = base >> 2;
      LMUL_F8: elems = base >> 3;
      default: elems = '0;
    endcase
    vlmax = VL_W'(elems);
    vill  = (cfg_vsew'(vsew) == VSEW_INVALID) || (cfg_lmul'(lmul) == LMUL_INVALID) ||
            (elems == '0);
  end

endmodule

// File: rtl/vproc_cfg_unit.sv
// Responder for UNIT_CFG instructions. It handles vsetvl and vector CSR
// read/write/set/clear, and it owns the vtype, vl, vstart, vxrm and vxsat state.
// Optional feature macro: VPROC_CFG_VSTART_EN. When it is defined, vstart is
// writable. When it is not defined, vstart stays 0.
//
// state           | meaning
// CFG_IDLE        | ready for a new cfg instruction
// CFG_WAIT_COMMIT | instruction held, waiting for commit or kill
// CFG_RESULT      | result presented until the core accepts it
module vproc_cfg_unit import vproc_pkg::*; #(
  parameter int unsigned VREG_W = 128,
  parameter int unsigned ID_W   = 3
) (
  input  logic                           clk_i,
  input  logic                           sync_rst_ni,
  input  logic                           req_valid_i,
  output logic                           req_ready_o,
  input  logic [ID_W-1:0]                req_id_i,
  input  logic [$bits(op_mode_cfg)-1:0]  req_mode_i,
  input  logic [31:0]                    req_xval_i,
  input  logic                           commit_valid_i,
  input  logic [ID_W-1:0]                commit_id_i,
  input  logic                           commit_kill_i,
  output logic                           res_valid_o,
  input  logic                           res_ready_i,
  output logic [ID_W-1:0]                res_id_o,
  output logic [31:0]                    res_data_o,
  input  logic                           vxsat_set_i,
  output logic [1:0]                     vsew_o,
  output logic [2:0]                     lmul_o,
  output logic [1:0]                     agnostic_o,
  output logic                           vill_o,
  output logic [$clog2(VREG_W):0]        vl_o,
  output logic [$clog2(VREG_W)-1:0]      vstart_o,
  output logic [1:0]                     vxrm_o,
  output logic                           vxsat_o
);

  localparam int unsigned VL_W = $clog2(VREG_W) + 1;
  localparam int unsigned VS_W = $clog2(VREG_W);
`ifdef VPROC_CFG_VSTART_EN
  localparam int unsigned RMW_W = VS_W;
`else
  localparam int unsigned RMW_W = 3;
`endif

  cfg_unit_state   state_q;
  logic [ID_W-1:0] id_q;
  op_mode_cfg      mode_q;
  logic [31:0]     xval_q;
  cfg_state        cfg_q, cfg_upd, cfg_next;
  logic [ID_W-1:0] res_id_q;
  logic [31:0]     res_data_q;

  op_mode_cfg       cur_mode;
  logic [31:0]      cur_xval;
  logic [4:0]       op_raw;
  logic [VL_W-1:0]  vlmax;
  logic             vill;
  logic             commit_hit, apply;
  logic [RMW_W-1:0] old_v, rmw_v;
  logic [31:0]      vlmax32, new_vl32, result;

  // In IDLE, the instruction comes straight from the request port so that a
  // same-cycle commit can be applied.
  assign cur_mode   = (state_q == CFG_IDLE) ? op_mode_cfg'(req_mode_i) : mode_q;
  assign cur_xval   = (state_q == CFG_IDLE) ? req_xval_i : xval_q;
  assign op_raw     = cur_mode.op;
  assign commit_hit = commit_valid_i &&
                      (commit_id_i == ((state_q == CFG_IDLE) ? req_id_i : id_q));
  assign apply      = commit_hit && !commit_kill_i &&
                      ((state_q == CFG_IDLE && req_valid_i) || state_q == CFG_WAIT_COMMIT);

  vproc_cfg_vlmax #(.VREG_W(VREG_W)) u_vlmax (
    .vsew  (cur_mode.vsew),
    .lmul  (cur_mode.lmul),
    .vlmax (vlmax),
    .vill  (vill)
  );

  // old value of the targeted CSR, and its read-modify-write result
  always_comb begin
    old_v = '0;
    case (op_raw[4:2])
      3'd1:    old_v = RMW_W'(cfg_q.vstart);
      3'd2:    old_v = RMW_W'(cfg_q.vxsat);
      3'd3:    old_v = RMW_W'(cfg_q.vxrm);
      3'd4:    old_v = RMW_W'({cfg_q.vxrm, cfg_q.vxsat});
      default: old_v = '0;
    endcase
    case (op_raw[1:0])
      2'd1:    rmw_v = old_v | cur_xval[RMW_W-1:0];
      2'd2:    rmw_v = old_v & ~cur_xval[RMW_W-1:0];
      default: rmw_v = cur_xval[RMW_W-1:0];
    endcase
  end

  // CSR update and scalar result for the current instruction
  always_comb begin
    cfg_upd  = cfg_q;
    result   = '0;
    new_vl32 = '0;
    vlmax32  = 32'(vlmax);
    case (op_raw[4:2])
      3'd0: begin
        case (op_raw[1:0])
          2'd0: begin
            if (vill) begin
              cfg_upd.vill     = 1'b1;
              cfg_upd.vsew     = VSEW_8;
              cfg_upd.lmul     = LMUL_1;
              cfg_upd.agnostic = 2'b00;
            end else begin
              cfg_upd.vill     = 1'b0;
              cfg_upd.vsew     = cur_mode.vsew;
              cfg_upd.lmul     = cur_mode.lmul;
              cfg_upd.agnostic = cur_mode.agnostic;
              if (cur_mode.vlmax)
                new_vl32 = vlmax32;
              else if (cur_mode.keep_vl)
                new_vl32 = (32'(cfg_q.vl) < vlmax32) ? 32'(cfg_q.vl) : vlmax32;
              else
                new_vl32 = (cur_xval < vlmax32) ? cur_xval : vlmax32;
            end
            cfg_upd.vl = CFG_VL_MAXW'(new_vl32);
            result     = new_vl32;
          end
          2'd1:    result = {cfg_q.vill, 23'b0, cfg_q.agnostic, 1'b0, cfg_q.vsew, cfg_q.lmul};
          2'd2:    result = 32'(cfg_q.vl);
          default: result = 32'(VREG_W / 8);
        endcase
      end
      3'd1: begin
        result = 32'(old_v);
`ifdef VPROC_CFG_VSTART_EN
        cfg_upd.vstart = CFG_VSTART_MAXW'(rmw_v);
`endif
      end
      3'd2: begin
        result        = 32'(old_v);
        cfg_upd.vxsat = rmw_v[0];
      end
      3'd3: begin
        result       = 32'(old_v);
        cfg_upd.vxrm = cfg_vxrm'(rmw_v[1:0]);
      end
      3'd4: begin
        result        = 32'(old_v);
        cfg_upd.vxsat = rmw_v[0];
        cfg_upd.vxrm  = cfg_vxrm'(rmw_v[2:1]);
      end
      default: result = '0;
    endcase
  end

  // A saturation pulse is ORed in after any update, so it wins over a clear
  always_comb begin
    cfg_next       = apply ? cfg_upd : cfg_q;
    cfg_next.vxsat = cfg_next.vxsat | vxsat_set_i;
  end

  // instruction FSM, CSR state and the registered result
  always_ff @(posedge clk_i) begin
    if (!sync_rst_ni) begin
      state_q    <= CFG_IDLE;
      id_q       <= '0;
      mode_q     <= op_mode_cfg'('0);
      xval_q     <= '0;
      cfg_q      <= CFG_STATE_RESET;
      res_id_q   <= '0;
      res_data_q <= '0;
    end else begin
      cfg_q <= cfg_next;
      case (state_q)
        CFG_IDLE: begin
          if (req_valid_i) begin
            id_q   <= req_id_i;
            mode_q <= cur_mode;
            xval_q <= req_xval_i;
            if (apply) begin
              state_q    <= CFG_RESULT;
              res_id_q   <= req_id_i;
              res_data_q <= result;
            end else if (!commit_hit) begin
              state_q <= CFG_WAIT_COMMIT;
            end
          end
        end
        CFG_WAIT_COMMIT: begin
          if (commit_hit) begin
            if (commit_kill_i) begin
              state_q <= CFG_IDLE;
            end else begin
              state_q    <= CFG_RESULT;
              res_id_q   <= id_q;
              res_data_q <= result;
            end
          end
        end
        CFG_RESULT: begin
          if (res_ready_i) state_q <= CFG_IDLE;
        end
        default: state_q <= CFG_IDLE;
      endcase
    end
  end

  assign req_ready_o = (state_q == CFG_IDLE);
  assign res_valid_o = (state_q == CFG_RESULT);
  assign res_id_o    = res_id_q;
  assign res_data_o  = res_data_q;
  assign vsew_o      = cfg_q.vsew;
  assign lmul_o      = cfg_q.lmul;
  assign agnostic_o  = cfg_q.agnostic;
  assign vill_o      = cfg_q.vill;
  assign vl_o        = VL_W'(cfg_q.vl);
  assign vstart_o    = VS_W'(cfg_q.vstart);
  assign vxrm_o      = cfg_q.vxrm;
  assign vxsat_o     = cfg_q.vxsat;

endmodule
